// File: rtl/vga_pkg.sv
// Visible-area geometry shared by the VGA pipeline blocks (800x600 mode).
package vga_pkg;
    localparam int HOR_BLANK_START = 800;
    localparam int VER_BLANK_START = 600;
endpackage

// File: rtl/vga_if.sv
// VGA timing plus pixel bundle passed between pipeline stages.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
    modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
endinterface

// File: rtl/draw_rect_move.sv
// Overlays a rectangle that bounces around the visible area, one step per frame.
// Define DRAW_RECT_OUTLINE_EN to draw only the 1-pixel border instead of a filled box.
module draw_rect_move
    import vga_pkg::*;
#(
    parameter int          RECT_W     = 64,
    parameter int          RECT_H     = 48,
    parameter logic [11:0] RECT_COLOR = 12'hF00,
    parameter int          STEP       = 2
) (
    input  logic  clk,
    input  logic  rst,
    vga_if.in     vga_in,
    input  logic  enable,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    vga_if.out    vga_out
);

    localparam logic [11:0] X_MAX  = 12'(HOR_BLANK_START - RECT_W);
    localparam logic [11:0] Y_MAX  = 12'(VER_BLANK_START - RECT_H);
    localparam logic [11:0] STEP_E = 12'(STEP);
    localparam logic [11:0] W_E    = 12'(RECT_W);
    localparam logic [11:0] H_E    = 12'(RECT_H);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t state;
    logic   back_x;   // 1 = moving left
    logic   back_y;   // 1 = moving up
    logic   vblnk_q;
    logic   tick;

    // Returns {flip, new_pos}. Reaching the far edge exactly already reverses,
    // so the box touches the boundary for a single frame before heading back.
    function automatic logic [12:0] bounce(input logic [11:0] pos, input logic back,
                                           input logic [11:0] lim);
        if (!back) begin
            if (pos + STEP_E >= lim) return {1'b1, lim};
            else                     return {1'b0, pos + STEP_E};
        end else begin
            if (pos < STEP_E)        return {1'b1, 12'd0};
            else                     return {1'b0, pos - STEP_E};
        end
    endfunction

    logic [11:0] x_e, y_e, h_e, v_e;
    logic [12:0] nx, ny;
    logic        in_rect, hit;

    always_comb begin
        x_e  = {1'b0, xpos};
        y_e  = {1'b0, ypos};
        h_e  = {1'b0, vga_in.hcount};
        v_e  = {1'b0, vga_in.vcount};
        tick = vga_in.vblnk & ~vblnk_q;
        nx   = bounce(x_e, back_x, X_MAX);
        ny   = bounce(y_e, back_y, Y_MAX);
        in_rect = !vga_in.hblnk && !vga_in.vblnk &&
                  (h_e >= x_e) && (h_e < x_e + W_E) &&
                  (v_e >= y_e) && (v_e < y_e + H_E);
`ifdef DRAW_RECT_OUTLINE_EN
        hit = in_rect && ((h_e == x_e) || (h_e == x_e + W_E - 12'd1) ||
                          (v_e == y_e) || (v_e == y_e + H_E - 12'd1));
`else
        hit = in_rect;
`endif
    end

    // Motion FSM: position only changes on the vblank rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            xpos    <= '0;
            ypos    <= '0;
            back_x  <= 1'b0;
            back_y  <= 1'b0;
            vblnk_q <= 1'b0;
        end else begin
            vblnk_q <= vga_in.vblnk;
            if (tick) begin
                case (state)
                    IDLE:    if (enable)  state <= RUN;
                    RUN:     if (!enable) state <= HOLD;
                    HOLD:    if (enable)  state <= RUN;
                    default: state <= IDLE;
                endcase
                if (enable) begin
                    xpos   <= nx[10:0];
                    ypos   <= ny[10:0];
                    back_x <= back_x ^ nx[12];
                    back_y <= back_y ^ ny[12];
                end
            end
        end
    end

    logic [10:0] h1, v1;
    logic        hs1, hb1, vs1, vb1, hit1;
    logic [11:0] rgb1;

    always_ff @(posedge clk) begin
        if (rst) begin
            h1 <= '0; v1 <= '0; hs1 <= 1'b0; hb1 <= 1'b0; vs1 <= 1'b0; vb1 <= 1'b0;
            rgb1 <= '0; hit1 <= 1'b0;
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            h1   <= vga_in.hcount;
            v1   <= vga_in.vcount;
            hs1  <= vga_in.hsync;
            hb1  <= vga_in.hblnk;
            vs1  <= vga_in.vsync;
            vb1  <= vga_in.vblnk;
            rgb1 <= vga_in.rgb;
            hit1 <= hit;
            vga_out.hcount <= h1;
            vga_out.vcount <= v1;
            vga_out.hsync  <= hs1;
            vga_out.hblnk  <= hb1;
            vga_out.vsync  <= vs1;
            vga_out.vblnk  <= vb1;
            vga_out.rgb    <= hit1 ? RECT_COLOR : rgb1;
        end
    end

endmodule

// File: tb/tb_draw_rect_move.sv
// Directed bench for draw_rect_move: pixel table, motion, hold, reset and bounce.
module tb_draw_rect_move;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [10:0] xpos, ypos;
    int          checks = 0;
    int          failures = 0;

`ifdef DRAW_RECT_OUTLINE_EN
    localparam bit OUTLINE = 1'b1;
`else
    localparam bit OUTLINE = 1'b0;
`endif

    vga_if vin ();
    vga_if vout ();

    draw_rect_move dut (
        .clk(clk), .rst(rst), .vga_in(vin), .enable(enable),
        .xpos(xpos), .ypos(ypos), .vga_out(vout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] h, v;
        logic        hs, hb, vs, vb;
        logic [11:0] rgb, exp;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input int h, input int v, input logic hs, input logic hb,
                                input logic vs, input logic vb, input logic [11:0] rgb,
                                input logic [11:0] exp);
        vec_t r;
        r.h = 11'(h); r.v = 11'(v); r.hs = hs; r.hb = hb; r.vs = vs; r.vb = vb;
        r.rgb = rgb; r.exp = exp;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        vin.vblnk = 1'b0;
        cyc(1);
        vin.vblnk = 1'b1;
        cyc(1);
    endtask

    task automatic apply(input vec_t t, input int idx);
        vin.hcount = t.h; vin.vcount = t.v; vin.hsync = t.hs; vin.hblnk = t.hb;
        vin.vsync = t.vs; vin.vblnk = t.vb; vin.rgb = t.rgb;
        cyc(2);
        check($sformatf("rgb[%0d]", idx), 32'(vout.rgb), 32'(t.exp));
        check($sformatf("timing[%0d]", idx),
              {vout.hcount, vout.vcount, vout.hsync, vout.hblnk, vout.vsync, vout.vblnk},
              {t.h, t.v, t.hs, t.hb, t.vs, t.vb});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(3);
        vin.vblnk = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        // Rectangle at (0,0): 64x48 box covers h 0..63, v 0..47.
        tbl[0]  = mk(10, 10, 1, 0, 0, 0, 12'h0A0, OUTLINE ? 12'h0A0 : 12'hF00);
        tbl[1]  = mk(64, 10, 0, 0, 1, 0, 12'h0A0, 12'h0A0);
        tbl[2]  = mk(63, 47, 0, 0, 0, 0, 12'h123, 12'hF00);
        tbl[3]  = mk(63, 48, 0, 0, 0, 0, 12'h123, 12'h123);
        tbl[4]  = mk(0,  0,  1, 0, 1, 0, 12'h0FF, 12'hF00);
        tbl[5]  = mk(10, 10, 0, 1, 0, 0, 12'h0A0, 12'h0A0);
        tbl[6]  = mk(10, 10, 0, 0, 0, 1, 12'h0A0, 12'h0A0);
        tbl[7]  = mk(0,  5,  0, 0, 0, 0, 12'h0A0, 12'hF00);
        tbl[8]  = mk(5,  5,  0, 0, 0, 0, 12'h0A0, OUTLINE ? 12'h0A0 : 12'hF00);
        // Rectangle at (6,6): covers h 6..69, v 6..53.
        tbl[9]  = mk(5,  10, 0, 0, 0, 0, 12'h0A0, 12'h0A0);
        tbl[10] = mk(6,  6,  0, 0, 0, 0, 12'h0A0, 12'hF00);
        tbl[11] = mk(69, 53, 0, 0, 0, 0, 12'h0A0, 12'hF00);
        tbl[12] = mk(70, 10, 0, 0, 0, 0, 12'h0A0, 12'h0A0);
        tbl[13] = mk(10, 54, 0, 0, 0, 0, 12'h0A0, 12'h0A0);

        enable = 1'b0;
        vin.hcount = 11'd10; vin.vcount = 11'd10; vin.hsync = 1'b1; vin.hblnk = 1'b0;
        vin.vsync = 1'b1; vin.vblnk = 1'b0; vin.rgb = 12'h0A0;

        // Reset clears position and the whole output stream even with live input.
        rst = 1'b1;
        cyc(3);
        check("reset_pos", {xpos, ypos}, 22'd0);
        check("reset_out", {vout.hcount, vout.vcount, vout.hsync, vout.hblnk,
                            vout.vsync, vout.vblnk, vout.rgb}, 0);
        rst = 1'b0;

        // Two frames with enable low: stays in IDLE at origin.
        tick(); tick();
        check("idle_2frames", {xpos, ypos}, 22'd0);

        for (int i = 0; i < 9; i++) apply(tbl[i], i);

        // Exact 2-cycle latency on a changing stream.
        vin.vblnk = 1'b0; vin.hblnk = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vin.hcount = 11'(200 + i);
            cyc(1);
            if (i >= 1) check($sformatf("latency[%0d]", i), 32'(vout.hcount), 32'(200 + i - 1));
        end

        // Enable pulse between ticks is ignored; only the level at the tick counts.
        enable = 1'b1; cyc(100); enable = 1'b0;
        tick();
        check("pulse_ignored", {xpos, ypos}, 22'd0);

        enable = 1'b1;
        tick(); tick(); tick();
        check("run_3ticks", {xpos, ypos}, {11'd6, 11'd6});

        for (int i = 9; i < 14; i++) apply(tbl[i], i);

        // RUN -> HOLD freezes; a mid-frame pulse in HOLD does nothing; HOLD -> RUN resumes.
        enable = 1'b0;
        tick();
        check("hold_frozen", {xpos, ypos}, {11'd6, 11'd6});
        vin.vblnk = 1'b0; cyc(2);
        enable = 1'b1; cyc(50); enable = 1'b0;
        tick();
        check("hold_pulse", {xpos, ypos}, {11'd6, 11'd6});
        enable = 1'b1;
        tick();
        check("hold_resume", {xpos, ypos}, {11'd8, 11'd8});

        // Reset mid-frame while running.
        vin.vblnk = 1'b0; vin.hblnk = 1'b0; vin.hcount = 11'd20; vin.vcount = 11'd300;
        vin.rgb = 12'h0A0;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        check("midrst_pos", {xpos, ypos}, 22'd0);
        check("midrst_out", {vout.hcount, vout.vcount, vout.hsync, vout.hblnk,
                             vout.vsync, vout.vblnk, vout.rgb}, 0);
        rst = 1'b0;
        cyc(5);
        check("midrst_no_move", {xpos, ypos}, 22'd0);
        apply(mk(5, 5, 0, 0, 0, 0, 12'h0A0, OUTLINE ? 12'h0A0 : 12'hF00), 100);
        apply(mk(0, 5, 0, 0, 0, 0, 12'h0A0, 12'hF00), 101);
        tick();
        check("midrst_fresh_tick", {xpos, ypos}, {11'd2, 11'd2});

        // Long run to the right edge; Y has already bounced off the bottom at tick 276.
        do_reset();
        enable = 1'b1;
        repeat (367) tick();
        check("edge_pre", {xpos, ypos}, {11'd734, 11'd370});
        tick();
        check("edge_hit", {xpos, ypos}, {11'd736, 11'd368});
        tick();
        check("edge_back", {xpos, ypos}, {11'd734, 11'd366});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
